// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
//   Shared types for the shift sequencer: the 2-bit shift opcode, the
//   sequencer FSM state and the opcode field width used to slice a program.
// -----------------------------------------------------------------------------
package shift_seq_pkg;

  // Width of one opcode field inside a packed program word.
  localparam int OP_W = 2;

  // One shift operation. Encodings match the program word layout.
  typedef enum logic [OP_W-1:0] {
    LEFT2 = 2'b00,  // acc << 1
    LEFT4 = 2'b01,  // acc << 2
    RIGHT = 2'b10,  // acc >> 1, logical
    HOLD  = 2'b11   // acc unchanged
  } op_e;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : shift_seq_pkg

// File: rtl/shift_step_unit.sv
// -----------------------------------------------------------------------------
// shift_step_unit
//   Combinational single-step shifter shared by every operation of a program.
//   Results are truncated to SIZE bits with zero fill.
//
//   Optional feature: define SHIFT_OVF_DETECT_EN to add lost_o, which is high
//   when the selected step shifts a nonzero bit out of the operand.
//
//   Ports:
//     acc_i   [SIZE-1:0]  current accumulator value
//     op_i    [1:0]       opcode (shift_seq_pkg::op_e encoding)
//     acc_o   [SIZE-1:0]  accumulator value after one step
//     lost_o              nonzero bit shifted out (SHIFT_OVF_DETECT_EN only)
// -----------------------------------------------------------------------------
module shift_step_unit
  import shift_seq_pkg::*;
#(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] acc_i,
  input  logic [OP_W-1:0] op_i,
  output logic [SIZE-1:0] acc_o
`ifdef SHIFT_OVF_DETECT_EN
  ,
  output logic            lost_o
`endif
);

  op_e op;
  assign op = op_e'(op_i);

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_o = acc_i;
    unique case (op)
      LEFT2:   acc_o = {acc_i[SIZE-2:0], 1'b0};
      LEFT4:   acc_o = {acc_i[SIZE-3:0], 2'b00};
      RIGHT:   acc_o = {1'b0, acc_i[SIZE-1:1]};
      HOLD:    acc_o = acc_i;
      default: acc_o = acc_i;
    endcase
  end

`ifdef SHIFT_OVF_DETECT_EN
  // Bits that fall off the operand for the selected step.
  always_comb begin
    lost_o = 1'b0;
    unique case (op)
      LEFT2:   lost_o = acc_i[SIZE-1];
      LEFT4:   lost_o = |acc_i[SIZE-1:SIZE-2];
      RIGHT:   lost_o = acc_i[0];
      HOLD:    lost_o = 1'b0;
      default: lost_o = 1'b0;
    endcase
  end
`endif

endmodule : shift_step_unit

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Applies a short program of shift operations to one operand, one operation
//   per clock, through a single shift_step_unit. One job in flight at a time,
//   valid/ready handshake on both sides.
//
//   Optional feature: define SHIFT_OVF_DETECT_EN to add the ovf output, a
//   sticky per-job flag set whenever a step shifts out a nonzero bit.
//
//   Parameters:
//     SIZE   data width in bits
//     STEPS  maximum number of operations per program
//     LW     width of len (derived from STEPS, not overridable)
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous active-low reset
//     in_valid   job request
//     in_ready   block can accept a job (IDLE, out of reset)
//     data_in    operand, sampled at acceptance
//     prog       op k at prog[2k+1:2k]; op 0 executes first
//     len        number of ops; values above STEPS are clamped
//     out_valid  result available (DONE)
//     out_ready  consumer takes the result
//     data_out   result (registered accumulator)
//     busy       high in RUN or DONE
//     ovf        shifted-out-bit flag (SHIFT_OVF_DETECT_EN only)
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter  int SIZE  = 5,
  parameter  int STEPS = 4,
  localparam int LW    = $clog2(STEPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE-1:0]       data_in,
  input  logic [OP_W*STEPS-1:0] prog,
  input  logic [LW-1:0]         len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE-1:0]       data_out,
  output logic                  busy
`ifdef SHIFT_OVF_DETECT_EN
  ,
  output logic                  ovf
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [SIZE-1:0]         acc_q,   acc_d;
  logic [LW-1:0]           idx_q,   idx_d;
  logic [LW-1:0]           len_q,   len_d;
  logic [OP_W*STEPS-1:0]   prog_q,  prog_d;
`ifdef SHIFT_OVF_DETECT_EN
  logic                    ovf_q,   ovf_d;
`endif

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [LW-1:0]   len_clamped;
  logic [OP_W-1:0] cur_op;
  logic [SIZE-1:0] step_acc;
`ifdef SHIFT_OVF_DETECT_EN
  logic            step_lost;
`endif

  assign len_clamped = (len > LW'(STEPS)) ? LW'(STEPS) : len;

  // Select the opcode for the current step. A compare-based mux keeps every
  // slice constant, so idx never has to be range-checked against prog_q.
  always_comb begin
    cur_op = prog_q[OP_W-1:0];
    for (int k = 0; k < STEPS; k++) begin
      if (idx_q == LW'(k)) begin
        cur_op = prog_q[OP_W*k +: OP_W];
      end
    end
  end

  shift_step_unit #(
    .SIZE (SIZE)
  ) u_step (
    .acc_i  (acc_q),
    .op_i   (cur_op),
    .acc_o  (step_acc)
`ifdef SHIFT_OVF_DETECT_EN
    ,
    .lost_o (step_lost)
`endif
  );

  // ---------------------------------------------------------------------------
  // FSM next-state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    len_d   = len_q;
    prog_d  = prog_q;
`ifdef SHIFT_OVF_DETECT_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d  = data_in;
          prog_d = prog;
          len_d  = len_clamped;
          idx_d  = '0;
`ifdef SHIFT_OVF_DETECT_EN
          ovf_d  = 1'b0;
`endif
          // An empty program passes the operand straight through.
          state_d = (len_clamped == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        acc_d = step_acc;
        idx_d = idx_q + LW'(1);
`ifdef SHIFT_OVF_DETECT_EN
        ovf_d = ovf_q | step_lost;
`endif
        if (idx_q == len_q - LW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Result and flag stay frozen until the consumer takes them; a new
        // job is only seen from IDLE, one edge later.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      prog_q  <= '0;
`ifdef SHIFT_OVF_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      prog_q  <= prog_d;
`ifdef SHIFT_OVF_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // in_ready is held low while reset is asserted so no job can be presented
  // into a block that is still being cleared.
  assign in_ready  = rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign data_out  = acc_q;
`ifdef SHIFT_OVF_DETECT_EN
  assign ovf       = ovf_q;
`endif

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//   Self-checking bench for shift_sequencer (SIZE=5, STEPS=4). Directed jobs
//   plus randomized jobs, each compared with an arithmetic reference model.
//   Build with SHIFT_OVF_DETECT_EN defined to also check the ovf flag.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam int SIZE  = 5;
  localparam int STEPS = 4;
  localparam int LW    = $clog2(STEPS + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:0]   data_in;
  logic [2*STEPS-1:0] prog;
  logic [LW-1:0]     len;
  logic              out_valid;
  logic              out_ready;
  logic [SIZE-1:0]   data_out;
  logic              busy;
`ifdef SHIFT_OVF_DETECT_EN
  logic              ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  shift_sequencer #(
    .SIZE  (SIZE),
    .STEPS (STEPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .prog      (prog),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
`ifdef SHIFT_OVF_DETECT_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: apply min(len, STEPS) ops with integer arithmetic mod 32.
  task automatic ref_model(input int d, input int p, input int l,
                           output int res, output int ovf_exp, output int n);
    int a;
    n       = (l > STEPS) ? STEPS : l;
    a       = d;
    ovf_exp = 0;
    for (int k = 0; k < n; k++) begin
      case ((p >> (2 * k)) % 4)
        0: begin if (a >= 16) ovf_exp = 1; a = (a * 2) % 32; end
        1: begin if (a >= 8)  ovf_exp = 1; a = (a * 4) % 32; end
        2: begin if (a % 2)   ovf_exp = 1; a = a / 2;        end
        default: ;
      endcase
    end
    res = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one job, check latency, hold the result for `stall` cycles,
  // then release it and check the return to IDLE.
  task automatic run_job(input int d, input int p, input int l, input int stall);
    int res, ovf_exp, n, guard;
    ref_model(d, p, l, res, ovf_exp, n);
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_before_job", in_ready, 1);
    in_valid = 1'b1;
    data_in  = SIZE'(d);
    prog     = 8'(p);
    len      = LW'(l);
    tick();
    // Scramble inputs: they must only matter at acceptance.
    in_valid = 1'b0;
    data_in  = SIZE'($urandom);
    prog     = 8'($urandom);
    len      = LW'($urandom);
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
    for (int k = 0; k < n; k++) begin
      check("valid_too_early", out_valid, 0);
      tick();
    end
    check("out_valid", out_valid, 1);
    check("data_out", data_out, res);
`ifdef SHIFT_OVF_DETECT_EN
    check("ovf", ovf, ovf_exp);
`endif
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", data_out, res);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_busy", busy, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    prog      = '0;
    len       = '0;
    out_ready = 1'b0;

    // Reset state.
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Worked example: 3 -> 6 -> 24 -> 12 -> 12.
    run_job(5'b00011, 8'hE4, 4, 0);

    // Empty program: pass-through, busy only in DONE.
    run_job(5'b10101, 8'h00, 0, 1);

    // Backpressure with a pending request.
    in_valid = 1'b1; data_in = 5'b00011; prog = 8'hE4; len = 3'd4;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_valid", out_valid, 1);
    check("bp_data", data_out, 12);
    in_valid = 1'b1; data_in = 5'b00111; prog = 8'hFF; len = 3'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", data_out, 12);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_back_idle", in_ready, 1);
    check("bp_not_taken", busy, 0);
    tick();
    in_valid = 1'b0;
    check("bp_new_accepted", busy, 1);
    tick();
    check("bp_new_valid", out_valid, 1);
    check("bp_new_data", data_out, 7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Clamp: len=7 executes exactly 4 ops.
    run_job(5'b00001, 8'b00_11_00_00, 7, 0);
    run_job(5'b11111, 8'b10_10_10_10, 7, 0);

    // Reset in the middle of a 4-op run, after 2 ops.
    in_valid = 1'b1; data_in = 5'b00011; prog = 8'hE4; len = 3'd4;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", data_out, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("midrst_in_ready", in_ready, 1);
    run_job(5'b00110, 8'b01_10_00_10, 4, 0);

`ifdef SHIFT_OVF_DETECT_EN
    run_job(5'b10001, 8'h00, 1, 0);
    run_job(5'b00001, 8'h02, 1, 0);
    run_job(5'b00100, 8'h00, 1, 0);
`endif

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_shift_sequencer

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-step shift controller that applies a short program of shift operations to one operand, one operation per clock, through a single shared shift-step unit.
- Sits between the CA2 datapath control and the shift resource.
- Valid/ready handshake on both input and output; one job in flight at a time.

Parameters:
- SIZE, 5, data width in bits.
- STEPS, 4, maximum number of operations per program.
- LW, $clog2(STEPS+1), width of the len field (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  job request.
- in_ready  output  1  block can accept a job.
- data_in  input  SIZE  operand.
- prog  input  2*STEPS  op k at prog[2k+1:2k]; op 0 executes first.
- len  input  LW  number of ops to execute; values above STEPS are clamped to STEPS.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- data_out  output  SIZE  result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Opcodes:
  - 00 LEFT2 = acc<<1.
  - 01 LEFT4 = acc<<2.
  - 10 RIGHT = acc>>1, logical.
  - 11 HOLD = acc unchanged.
  - Results are truncated to SIZE bits, zero-fill.
- Reset (rst=0, async): state=IDLE, acc=0, idx=0, data_out=0, out_valid=0, busy=0. in_ready=1 once rst is deasserted.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge, latch data_in into acc and latch prog and the clamped len.
  - If len==0, go to DONE; otherwise go to RUN with idx=0.
- RUN:
  - in_ready=0.
  - Each edge: acc <= step(acc, op[idx]), idx <= idx+1.
  - On the edge that executes idx==len-1, go to DONE.
- DONE:
  - out_valid=1 and data_out=acc; both are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - A new job can be accepted at the earliest on the next edge; there is no same-cycle turnaround.
- Latency: if a job is accepted at edge T, out_valid is first high in the cycle after edge T+len. The len=0 case passes the operand through, with out_valid high the cycle after acceptance.
- data_out is registered and equals acc.
- in_valid is ignored outside IDLE. prog, len and data_in are only sampled at acceptance.
- Reset mid-job aborts the job immediately, with no output.
- out_ready while not in DONE is ignored.

Optional Feature:
- Macro: SHIFT_OVF_DETECT_EN.
- With the macro defined:
  - Extra output port ovf (1 bit) and a sticky per-job flag.
  - The flag is cleared on acceptance.
  - It is set when a nonzero bit is shifted out by any step: LEFT2 checks acc[SIZE-1], LEFT4 checks acc[SIZE-1:SIZE-2], RIGHT checks acc[0].
  - ovf is valid alongside out_valid and resets to 0.
- Without the macro: no ovf port and no flag logic. All other behaviour is identical.

Decomposition:
- Package shift_seq_pkg holds:
  - the opcode typedef (2-bit enum LEFT2, LEFT4, RIGHT, HOLD);
  - the FSM state typedef (IDLE, RUN, DONE);
  - the opcode field width constant 2.
- One sub-module, shift_step_unit: a combinational single-step shifter with acc and op inputs, next-acc output and, under the macro, a lost-bits output.
- The sequencer owns all registers and the FSM.

Test Plan:
- SIZE=5, data_in=5'b00011, ops [LEFT2, LEFT4, RIGHT, HOLD], len=4:
  - acc goes 3→6→24→12→12.
  - data_out=5'b01100, with out_valid first high the cycle after edge T+4.
- len=0, data_in=5'b10101: data_out=5'b10101 the cycle after acceptance; busy=1 only while in DONE.
- Backpressure:
  - Complete a job, then hold out_ready=0 for 3 cycles while driving in_valid=1 with a new operand.
  - data_out and out_valid stay stable and in_ready=0.
  - The new job is accepted only after out_ready=1 returns the block to IDLE.
- len=7 with STEPS=4: clamped, exactly 4 ops execute; result matches a 4-op reference model.
- Drive rst=0 mid-RUN (after 2 of 4 ops):
  - Outputs are 0 immediately, before the next clock edge.
  - After release, in_ready=1 and a fresh job gives the correct result.
- With SHIFT_OVF_DETECT_EN:
  - data_in=5'b10001, LEFT2, len=1: data_out=5'b00010, ovf=1.
  - data_in=5'b00001, RIGHT: data_out=0, ovf=1.
  - data_in=5'b00100, LEFT2: ovf=0.
